// File: rtl/gf_lsb_serial_mult_if.sv
// Operand/result handshake bundle for the digit-serial GF(2^M) multiplier.
// The master side issues operands and accepts results; the slave side is the multiplier.
interface gf_lsb_serial_mult_if #(
    parameter int M = 8
);
    logic         in_valid;
    logic         in_ready;
    logic [M-1:0] a;
    logic [M-1:0] b;
    logic [M-1:0] poly;
    logic         out_valid;
    logic         out_ready;
    logic [M-1:0] p;
    logic         busy;

    modport master (
        output in_valid, a, b, poly, out_ready,
        input  in_ready, out_valid, p, busy
    );

    modport slave (
        input  in_valid, a, b, poly, out_ready,
        output in_ready, out_valid, p, busy
    );
endinterface

// File: rtl/gf_lsb_serial_mult.sv
// Digit-serial LSB-first GF(2^M) multiplier, D bits of b per cycle; result valid M/D cycles after accept.
// Result held in DONE until out_ready; a new operation can be accepted on the same edge the result retires.
module gf_lsb_serial_mult #(
    parameter int M = 8,
    parameter int D = 1
) (
    input  logic              clk,
    input  logic              rst,
    gf_lsb_serial_mult_if.slave bus
);
    localparam int            NDIG = M / D;
    localparam int            CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state_q;
    logic [M-1:0]  a_q;
    logic [M-1:0]  b_q;
    logic [M-1:0]  poly_q;
    logic [M-1:0]  acc_q;
    logic [M-1:0]  p_q;
    logic [CW-1:0] cnt_q;
    logic          out_valid_q;
    logic          busy_q;

    logic [M-1:0]  a_d;
    logic [M-1:0]  acc_d;
    logic [M-1:0]  b_d;
    logic          accept;
    logic          retire;

    assign bus.in_ready  = !rst && (state_q == IDLE || (state_q == DONE && bus.out_ready));
    assign accept        = bus.in_valid && bus.in_ready;
    assign retire        = out_valid_q && bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.p         = p_q;
    assign bus.busy      = busy_q;

    // Each bit-step accumulates the current a before multiplying a by x and reducing.
    always_comb begin
        a_d   = a_q;
        acc_d = acc_q;
        for (int j = 0; j < D; j++) begin
            if (b_q[j]) begin
                acc_d = acc_d ^ a_d;
            end
            a_d = {a_d[M-2:0], 1'b0} ^ (a_d[M-1] ? poly_q : '0);
        end
        b_d = b_q >> D;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            poly_q      <= '0;
            acc_q       <= '0;
            p_q         <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else if (accept) begin
            // Covers both the IDLE start and the DONE retire-and-restart overlap.
            a_q         <= bus.a;
            b_q         <= bus.b;
            poly_q      <= bus.poly;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= RUN;
        end else begin
            case (state_q)
                RUN: begin
                    a_q   <= a_d;
                    acc_q <= acc_d;
                    b_q   <= b_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        p_q         <= acc_d;
                        out_valid_q <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (retire) begin
                        out_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/gf_lsb_serial_mult.md
Name: gf_lsb_serial_mult

Overview:
Sequential, digit-serial LSB-first GF(2^M) multiplier. It is the parametrised successor to the team's unrolled 8-bit combinational LSB-first multiplier. Field width M, digit size D and the field polynomial are configurable. Operands are accepted and results returned over valid/ready handshakes, and the block is sized to replace the unrolled array wherever area matters more than latency.

Parameters:
M, 8, field degree; operand and result width in bits (M >= 2).
D, 1, bits of b consumed per cycle; M must be an exact multiple of D (1 <= D <= M).

Ports:
clk  input  1  clock; all state updates on rising edge.
rst  input  1  synchronous reset, active-high.
in_valid  input  1  operand set a/b/poly is valid.
in_ready  output  1  block can accept an operation this cycle.
a  input  M  multiplicand.
b  input  M  multiplier; consumed LSB first.
poly  input  M  low M coefficients of the field polynomial; the x^M term is implicit.
out_valid  output  1  p holds a finished product.
out_ready  input  1  downstream accepts p.
p  output  M  product a*b mod (x^M + poly).
busy  output  1  high while in RUN.

Behaviour:
- Reset (rst high at a clock edge):
  - state=IDLE, out_valid=0, p=0, busy=0, digit counter=0, internal a/b/acc/poly registers=0.
  - in_ready is forced to 0 in any cycle where rst is high.
  - Reset has priority over every other event, including an operation already in RUN.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready: latch a_r=a, b_r=b, poly_r=poly, acc=0, cnt=0, and go to RUN.
  - RUN: busy=1, in_ready=0. Each cycle performs D bit-steps. Bit-step j uses bit b_r[j]:
    - acc ^= (b_r[j] ? a_r : 0)
    - a_r = (a_r<<1 truncated to M bits) ^ (old a_r[M-1] ? poly_r : 0)
    - The acc update uses a_r before that step's shift.
  - RUN, continued: after the D steps, b_r shifts right by D and cnt increments. When cnt reaches M/D-1, the final digit's result is written to p, out_valid is set to 1, and the state goes to DONE. No partial value ever appears on p.
  - DONE: out_valid=1; p and out_valid stay stable until out_ready=1. On out_valid&&out_ready, out_valid drops next cycle and the state returns to IDLE, unless a new operation is accepted in the same cycle.
- Back-to-back operation:
  - in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
  - If in DONE with out_ready=1 and in_valid=1, the result retires and the new operands are latched on the same edge, with the state going straight to RUN.
- Latency: out_valid rises exactly M/D cycles after the accepting edge. Sustained throughput is one result per M/D+1 cycles when always ready; the DONE-to-RUN overlap removes the IDLE cycle.
- Input stability: a, b and poly are sampled only on the accept edge. Changes at any other time have no effect.
- Arithmetic:
  - Purely XOR/AND; no carries.
  - poly_r is held constant for the whole operation, so results are correct for any poly value, including non-irreducible ones, as modular reduction.
  - Operands a or b >= 2^M cannot occur because they are M bits wide.
- Boundary cases:
  - b=0 or a=0 -> p=0 with full latency (no early exit).
  - b=1 -> p=a.
  - D=M -> single-cycle RUN.
  - out_ready held low -> DONE held indefinitely and no new operands are accepted.
- Counter width: clog2(M/D) bits, minimum 1.

Test Plan:
1. M=8, D=1, poly=0x1B, a=0x57, b=0x83 -> out_valid exactly 8 cycles after accept, p=0xC1; then a=0x57, b=0x13 -> p=0xFE.
2. M=8, D=2 and D=8, poly=0x1B, a=0x57, b=0x83 -> p=0xC1 with latency 4 and 1 cycles respectively; busy high for exactly that many cycles.
3. M=4, D=1, poly=0x3, a=0xB, b=0x7 -> p=0x4. Then a=0x9, b=0x1 -> p=0x9. Then a=0x0, b=0xF -> p=0x0, still with 4-cycle latency.
4. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> p stays stable, in_ready=0 throughout. Then raise out_ready with in_valid=1 (a=0x02, b=0x80, poly=0x1B) -> old result retires and the new op is accepted on the same edge; next p=0x1B after 8 cycles.
5. Reset mid-operation: assert rst for one cycle at cycle 3 of RUN -> next cycle state=IDLE, out_valid=0, p=0, busy=0. in_ready=0 during the rst cycle and 1 afterwards; no stale result appears.
6. Operand change during RUN: toggle a/b/poly randomly after accept -> result still matches the accepted operands. Random regression across M in {4, 8, 16}, D in {1, 2, 4} against a bit-level reference model, 1000 ops each, with random in_valid/out_ready.
